// File: rtl/mmio_responder.sv
// MMIO responder for the top 16 data addresses: LED register, synchronised
// switches, countdown timer with sticky expiry, and a push FIFO for a consumer.
module mmio_responder #(
  parameter logic [7:0]  IO_BASE    = 8'hF0,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  input  logic        wren,
  input  logic [9:0]  sw,
  input  logic        fifo_pop,
  output logic [15:0] rdata,
  output logic        io_sel,
  output logic [9:0]  ledr,
  output logic [15:0] fifo_data,
  output logic        fifo_valid,
  output logic        timer_irq
);

  localparam int unsigned         PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam int unsigned         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [3:0]          FIFO_MAX  = 4'(FIFO_DEPTH);

  localparam logic [3:0] OFF_LEDR  = 4'd0;
  localparam logic [3:0] OFF_SW    = 4'd1;
  localparam logic [3:0] OFF_TMR   = 4'd2;
  localparam logic [3:0] OFF_CTRL  = 4'd3;
  localparam logic [3:0] OFF_PUSH  = 4'd4;
  localparam logic [3:0] OFF_STAT  = 4'd5;

  logic [15:0]        rdata_q, rdata_d;
  logic               io_sel_q, io_sel_d;
  logic [9:0]         ledr_q, ledr_d;
  logic [9:0]         sw_meta_q, sw_sync_q;
  logic [15:0]        load_q, load_d;
  logic [15:0]        count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               en_q, en_d;
  logic               autoreload_q, autoreload_d;
  logic               expired_q, expired_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [15:0]        mem_d [FIFO_DEPTH];

  logic       hit;
  logic [3:0] off;
  logic       wr_ledr, wr_tmr, wr_ctrl, wr_push, wr_stat;
  logic       tick;
  logic       fifo_empty, fifo_full;
  logic       push_ok, pop_ok;

  always_comb begin
    hit     = (addr[7:4] == IO_BASE[7:4]);
    off     = addr[3:0];
    wr_ledr = wren && hit && (off == OFF_LEDR);
    wr_tmr  = wren && hit && (off == OFF_TMR);
    wr_ctrl = wren && hit && (off == OFF_CTRL);
    wr_push = wren && hit && (off == OFF_PUSH);
    wr_stat = wren && hit && (off == OFF_STAT);
  end

  always_comb begin
    ledr_d = ledr_q;
    if (wr_ledr) ledr_d = wdata[9:0];
  end

  // A TMR write wins over a tick; an expiry set wins over a write-1 clear.
  always_comb begin
    tick         = en_q && (count_q != '0) && (presc_q == PRESC_MAX);
    presc_d      = '0;
    load_d       = load_q;
    count_d      = count_q;
    en_d         = en_q;
    autoreload_d = autoreload_q;
    expired_d    = expired_q;

    if (!wr_tmr && en_q && (count_q != '0))
      presc_d = tick ? '0 : presc_q + 1'b1;

    if (wr_ctrl) begin
      en_d         = wdata[0];
      autoreload_d = wdata[1];
      if (wdata[15]) expired_d = 1'b0;
    end

    if (wr_tmr) begin
      load_d  = wdata;
      count_d = wdata;
    end else if (tick) begin
      if (count_q == 16'd1) begin
        expired_d = 1'b1;
        count_d   = autoreload_q ? load_q : '0;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  always_comb begin
    fifo_empty = (fcnt_q == '0);
    fifo_full  = (fcnt_q == FIFO_MAX);
    pop_ok     = fifo_pop && !fifo_empty;
    push_ok    = wr_push && (!fifo_full || pop_ok);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fcnt_d     = fcnt_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (wr_stat && wdata[15]) overflow_d = 1'b0;
    if (wr_push && !push_ok)  overflow_d = 1'b1;

    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_ok) rptr_d = rptr_q + 1'b1;

    if (push_ok && !pop_ok)      fcnt_d = fcnt_q + 4'd1;
    else if (pop_ok && !push_ok) fcnt_d = fcnt_q - 4'd1;
  end

  always_comb begin
    io_sel_d = hit;
    rdata_d  = '0;
    if (hit) begin
      case (off)
        OFF_LEDR: rdata_d = {6'b0, ledr_q};
        OFF_SW:   rdata_d = {6'b0, sw_sync_q};
        OFF_TMR:  rdata_d = count_q;
        OFF_CTRL: rdata_d = {expired_q, 13'b0, autoreload_q, en_q};
        OFF_STAT: rdata_d = {overflow_q, 5'b0, fifo_full, fifo_empty, 5'b0, fcnt_q[2:0]};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      rdata_q      <= '0;
      io_sel_q     <= 1'b0;
      ledr_q       <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      load_q       <= '0;
      count_q      <= '0;
      presc_q      <= '0;
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      expired_q    <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fcnt_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      io_sel_q     <= io_sel_d;
      ledr_q       <= ledr_d;
      sw_meta_q    <= sw;
      sw_sync_q    <= sw_meta_q;
      load_q       <= load_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      expired_q    <= expired_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fcnt_q       <= fcnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: the count masks stale entries.
  always_ff @(posedge clk_50MHz) begin
    mem_q <= mem_d;
  end

  assign rdata      = rdata_q;
  assign io_sel     = io_sel_q;
  assign ledr       = ledr_q;
  assign timer_irq  = expired_q;
  assign fifo_valid = !fifo_empty;
  assign fifo_data  = fifo_empty ? '0 : mem_q[rptr_q];

endmodule
